// File: rtl/tb_uart_xcvr.sv
// tb_uart_xcvr: full-duplex 8N1 host-side UART partner with tx_start edge handshake and ready flag
// Ports: clock/reset (async, active-high); ser_rx/ser_tx serial lines (idle high);
//   tx_start/tx_data/tx_busy transmit handshake; rx_data/rx_valid received byte;
//   tx_clear_req sticky "chip ready" flag set on receive, cleared on accepted tx start.
// Option: RX_FRAME_CHECK_EN adds rx_frame_err and rejects bytes whose stop bit is 0.
module tb_uart_xcvr #(
  parameter int CLKS_PER_BIT = 4167
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ser_rx,
  output logic       ser_tx,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_busy,
  output logic       tx_clear_req,
  output logic [7:0] rx_data,
  output logic       rx_valid
`ifdef RX_FRAME_CHECK_EN
  ,
  output logic       rx_frame_err
`endif
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] MID = CW'(CLKS_PER_BIT / 2 - 1);
  typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_st_t;
  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_WAIT} rx_st_t;
  tx_st_t tx_st, tx_st_n;
  rx_st_t rx_st, rx_st_n;
  logic [CW-1:0] tx_cnt, tx_cnt_n, rx_cnt, rx_cnt_n;
  logic [2:0] tx_bit, tx_bit_n, rx_bit, rx_bit_n;
  logic [7:0] tx_sh, tx_sh_n, rx_sh, rx_sh_n, rx_data_n;
  logic ser_tx_n, tx_busy_n, tx_start_q, tx_go, clr_n, rx_valid_n;
  logic rx_s1, rx_s2, rx_q;
`ifdef RX_FRAME_CHECK_EN
  logic ferr_n;
`endif
  // edges arriving while busy are dropped, never queued
  assign tx_go = tx_start && !tx_start_q && tx_st == T_IDLE;
  always_comb begin
    tx_st_n = tx_st;
    tx_cnt_n = tx_cnt == LAST ? '0 : tx_cnt + 1'b1;
    tx_bit_n = tx_bit;
    tx_sh_n = tx_sh;
    ser_tx_n = ser_tx;
    tx_busy_n = tx_busy;
    if (tx_go) begin
      tx_st_n = T_START;
      tx_cnt_n = '0;
      tx_sh_n = tx_data;
      ser_tx_n = 1'b0;
      tx_busy_n = 1'b1;
    end else if (tx_st != T_IDLE && tx_cnt == LAST) begin
      case (tx_st)
        T_START: begin
          tx_st_n = T_DATA;
          tx_bit_n = '0;
          ser_tx_n = tx_sh[0];
        end
        T_DATA: begin
          tx_sh_n = tx_sh >> 1;
          tx_bit_n = tx_bit + 1'b1;
          ser_tx_n = tx_bit == 3'd7 ? 1'b1 : tx_sh[1];
          tx_st_n = tx_bit == 3'd7 ? T_STOP : T_DATA;
        end
        default: begin
          tx_st_n = T_IDLE;
          tx_busy_n = 1'b0;
          ser_tx_n = 1'b1;
        end
      endcase
    end
  end
  always_comb begin
    rx_st_n = rx_st;
    rx_cnt_n = rx_cnt + 1'b1;
    rx_bit_n = rx_bit;
    rx_sh_n = rx_sh;
    rx_data_n = rx_data;
    rx_valid_n = 1'b0;
    // a set from a completing receive overrides a coincident clear
    clr_n = tx_go ? 1'b0 : tx_clear_req;
`ifdef RX_FRAME_CHECK_EN
    ferr_n = 1'b0;
`endif
    case (rx_st)
      R_IDLE: begin
        rx_cnt_n = '0;
        if (rx_q && !rx_s2) rx_st_n = R_START;
      end
      R_START: if (rx_cnt == MID) begin
        rx_cnt_n = '0;
        rx_bit_n = '0;
        rx_st_n = rx_s2 ? R_IDLE : R_DATA;
      end
      R_DATA: if (rx_cnt == LAST) begin
        rx_cnt_n = '0;
        rx_sh_n = {rx_s2, rx_sh[7:1]};
        rx_bit_n = rx_bit + 1'b1;
        rx_st_n = rx_bit == 3'd7 ? R_STOP : R_DATA;
      end
      R_STOP: if (rx_cnt == LAST) begin
        rx_cnt_n = '0;
`ifdef RX_FRAME_CHECK_EN
        if (!rx_s2) begin
          ferr_n = 1'b1;
          rx_st_n = R_WAIT;
        end else
`endif
        begin
          rx_data_n = rx_sh;
          rx_valid_n = 1'b1;
          clr_n = 1'b1;
          rx_st_n = R_IDLE;
        end
      end
      default: begin
        rx_cnt_n = '0;
        if (rx_s2) rx_st_n = R_IDLE;
      end
    endcase
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      tx_st <= T_IDLE;
      tx_cnt <= '0;
      tx_bit <= '0;
      tx_sh <= '0;
      ser_tx <= 1'b1;
      tx_busy <= 1'b0;
      tx_start_q <= 1'b0;
    end else begin
      tx_st <= tx_st_n;
      tx_cnt <= tx_cnt_n;
      tx_bit <= tx_bit_n;
      tx_sh <= tx_sh_n;
      ser_tx <= ser_tx_n;
      tx_busy <= tx_busy_n;
      tx_start_q <= tx_start;
    end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      rx_st <= R_IDLE;
      rx_cnt <= '0;
      rx_bit <= '0;
      rx_sh <= '0;
      rx_data <= '0;
      rx_valid <= 1'b0;
      tx_clear_req <= 1'b0;
      {rx_s1, rx_s2, rx_q} <= 3'b111;
    end else begin
      rx_st <= rx_st_n;
      rx_cnt <= rx_cnt_n;
      rx_bit <= rx_bit_n;
      rx_sh <= rx_sh_n;
      rx_data <= rx_data_n;
      rx_valid <= rx_valid_n;
      tx_clear_req <= clr_n;
      {rx_s1, rx_s2, rx_q} <= {ser_rx, rx_s1, rx_s2};
    end
`ifdef RX_FRAME_CHECK_EN
  always_ff @(posedge clock or posedge reset)
    if (reset) rx_frame_err <= 1'b0;
    else rx_frame_err <= ferr_n;
`endif
endmodule

// File: tb/tb_tb_uart_xcvr.sv
// tb_tb_uart_xcvr: randomized self-checking bench for tb_uart_xcvr against a frame-level model
module tb_tb_uart_xcvr;
  localparam int C = 16;
  logic clock = 1'b0, reset = 1'b1, ser_rx = 1'b1, tx_start = 1'b0;
  logic [7:0] tx_data = '0;
  logic ser_tx, tx_busy, tx_clear_req, rx_valid;
  logic [7:0] rx_data;
  int tests = 0, fails = 0, n_valid = 0, n_ferr = 0, v0;
  logic [7:0] got[$];
  logic [7:0] echo[4] = '{8'd61, 8'd15, 8'd18, 8'd55};
  logic [7:0] r;
`ifdef RX_FRAME_CHECK_EN
  logic rx_frame_err;
`endif
  always #5 clock = ~clock;
  tb_uart_xcvr #(.CLKS_PER_BIT(C)) dut (
    .clock(clock),
    .reset(reset),
    .ser_rx(ser_rx),
    .ser_tx(ser_tx),
    .tx_start(tx_start),
    .tx_data(tx_data),
    .tx_busy(tx_busy),
    .tx_clear_req(tx_clear_req),
    .rx_data(rx_data),
    .rx_valid(rx_valid)
`ifdef RX_FRAME_CHECK_EN
    ,
    .rx_frame_err(rx_frame_err)
`endif
  );
  always @(negedge clock) begin
    if (rx_valid) begin
      n_valid++;
      got.push_back(rx_data);
    end
`ifdef RX_FRAME_CHECK_EN
    if (rx_frame_err) n_ferr++;
`endif
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask
  task automatic cycles(input int n);
    repeat (n) @(negedge clock);
  endtask
  // model: a frame is start 0, data LSB first, stop 1, each held C cycles; busy lasts 10*C
  task automatic send_byte(input logic [7:0] d, input bit retrig, input bit chk_clr);
    logic [9:0] seen;
    int busy_len;
    @(negedge clock);
    tx_data = d;
    tx_start = 1'b1;
    @(negedge clock);
    check("busy_rise", tx_busy, 1);
    if (chk_clr) check("clr_on_start", tx_clear_req, 0);
    tx_data = ~d;
    seen = '0;
    busy_len = 0;
    for (int i = 0; i < 10 * C + 40; i++) begin
      if (i % C == C / 2 && i < 10 * C) seen[i/C] = ser_tx;
      if (tx_busy) busy_len++;
      if (retrig && i == 40) tx_start = 1'b0;
      if (retrig && i == 60) tx_start = 1'b1;
      @(negedge clock);
    end
    check("frame", seen, {1'b1, d, 1'b0});
    check("busy_len", busy_len, 10 * C);
    tx_start = 1'b0;
  endtask
  task automatic drive_rx(input logic [7:0] d, input logic stop);
    logic [9:0] f;
    f = {stop, d, 1'b0};
    for (int b = 0; b < 10; b++) begin
      ser_rx = f[b];
      cycles(C);
    end
    ser_rx = 1'b1;
    cycles(6);
  endtask
  task automatic expect_rx(input logic [7:0] d);
    check("rx_count", got.size(), 1);
    if (got.size() > 0) check("rx_byte", got[0], d);
    got.delete();
  endtask
  task automatic wait_clr();
    int k;
    k = 0;
    while (!tx_clear_req && k < 400) begin
      cycles(1);
      k++;
    end
    check("clr_set", tx_clear_req, 1);
  endtask
  initial begin
    cycles(3);
    check("rst_ser_tx", ser_tx, 1);
    check("rst_busy", tx_busy, 0);
    check("rst_clr", tx_clear_req, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_rx_valid", rx_valid, 0);
    reset = 1'b0;
    cycles(3);
    send_byte(8'h3D, 1'b0, 1'b1);
    send_byte(8'($urandom), 1'b1, 1'b1);
    drive_rx(8'h0F, 1'b1);
    expect_rx(8'h0F);
    check("clr_after_rx", tx_clear_req, 1);
    send_byte(8'd15, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      r = 8'($urandom);
      drive_rx(r, 1'b1);
      wait_clr();
      expect_rx(r);
      send_byte(echo[i], 1'b0, 1'b1);
    end
    for (int i = 0; i < 3; i++) begin
      r = 8'($urandom);
      fork
        send_byte(8'($urandom), 1'b0, 1'b0);
        drive_rx(r, 1'b1);
      join
      expect_rx(r);
      check("clr_dup", tx_clear_req, 1);
    end
    send_byte(8'($urandom), 1'b0, 1'b1);
    v0 = n_valid;
    drive_rx(8'hA5, 1'b0);
    cycles(C);
`ifdef RX_FRAME_CHECK_EN
    check("ferr_count", n_ferr, 1);
    check("ferr_no_valid", n_valid, v0);
    check("ferr_clr", tx_clear_req, 0);
    got.delete();
`else
    expect_rx(8'hA5);
    check("stop0_clr", tx_clear_req, 1);
`endif
    v0 = n_valid;
    ser_rx = 1'b0;
    cycles(4);
    ser_rx = 1'b1;
    cycles(12 * C);
    check("glitch", n_valid, v0);
    tx_data = 8'($urandom);
    tx_start = 1'b1;
    ser_rx = 1'b0;
    cycles(50);
    check("mid_busy", tx_busy, 1);
    #3 reset = 1'b1;
    #1;
    check("rst_mid_ser_tx", ser_tx, 1);
    check("rst_mid_busy", tx_busy, 0);
    ser_rx = 1'b1;
    tx_start = 1'b0;
    cycles(2);
    reset = 1'b0;
    cycles(12 * C);
    check("rst_no_rx", n_valid, v0);
    check("rst_idle_busy", tx_busy, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
